session_timeout_ctrl: RTL and testbench

Timebase controller for the POS terminal. It turns the 50 MHz system clock into single-cycle enable strobes (no derived clocks) and sequences a transaction-session timeout. Keypad, card reader and display logic use it: they start a session, report user activity, pause it during host communication, and consume the expiry.

---
 rtl/pos_timing_pkg.sv | 19 +
 rtl/session_timeout_ctrl_if.sv | 36 +++
 rtl/tick_prescaler.sv | 32 +++
 rtl/session_timeout_ctrl.sv | 149 ++++++++++++++
 tb/tb_session_timeout_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pos_timing_pkg.sv
// Shared timing definitions for the POS timebase blocks: system clock rate,
// session state encoding and the prescaler counter width helper.
package pos_timing_pkg;

  localparam int SYS_CLK_HZ = 50_000_000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } session_state_t;

  // Bits needed to count 0..div-1; never narrower than one bit.
  function automatic int presc_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/session_timeout_ctrl_if.sv
// Control/status bundle between the session timeout controller and its users.
// SESSION_WARN_BEEP_EN adds the beepOut buzzer output.
interface session_timeout_ctrl_if;
  logic       start;
  logic       activity;
  logic       pause;
  logic       abort;
  logic [7:0] timeoutLoad;
  logic       tick;
  logic       secTick;
  logic [7:0] remaining;
  logic       running;
  logic       warning;
  logic       expired;
  logic       timedOut;
`ifdef SESSION_WARN_BEEP_EN
  logic       beepOut;
`endif

  modport master (
`ifdef SESSION_WARN_BEEP_EN
    input  beepOut,
`endif
    output start, activity, pause, abort, timeoutLoad,
    input  tick, secTick, remaining, running, warning, expired, timedOut
  );

  modport slave (
`ifdef SESSION_WARN_BEEP_EN
    output beepOut,
`endif
    input  start, activity, pause, abort, timeoutLoad,
    output tick, secTick, remaining, running, warning, expired, timedOut
  );

endinterface

// File: rtl/tick_prescaler.sv
// Free-running divider producing a registered one-cycle strobe every DIV cycles.
module tick_prescaler #(
  parameter int DIV = 50_000
) (
  input  logic clockIn,
  input  logic reset,
  output logic tick
);
  import pos_timing_pkg::*;

  localparam int               CNT_W    = presc_width(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_count;
  logic             r_tick;

  always_ff @(posedge clockIn or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_tick  <= 1'b0;
    end else if (r_count == CNT_LAST) begin
      r_count <= '0;
      r_tick  <= 1'b1;
    end else begin
      r_count <= r_count + 1'b1;
      r_tick  <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/session_timeout_ctrl.sv
// POS session timebase: tick strobe plus a pausable, reloadable session countdown.
// Optional buzzer output when SESSION_WARN_BEEP_EN is defined.
module session_timeout_ctrl #(
  parameter int CLK_HZ    = pos_timing_pkg::SYS_CLK_HZ,
  parameter int TICK_HZ   = 1000,
  parameter int TIMEOUT_S = 30,
  parameter int WARN_S    = 5
) (
  input logic                   clockIn,
  input logic                   reset,
  session_timeout_ctrl_if.slave bus
);
  import pos_timing_pkg::*;

  localparam int               SEC_W       = presc_width(TICK_HZ);
  localparam logic [SEC_W-1:0] SEC_LAST    = SEC_W'(TICK_HZ - 1);
  localparam logic [7:0]       DEFAULT_LEN = 8'(TIMEOUT_S);
  localparam logic [7:0]       WARN_LEN    = 8'(WARN_S);

  session_state_t   r_state, w_state_next;
  logic [SEC_W-1:0] r_sec_count, w_sec_count_next;
  logic [7:0]       r_session_len, w_session_len_next;
  logic [7:0]       r_remaining, w_remaining_next;
  logic             r_sec_tick, w_sec_tick_next;
  logic             r_expired, w_expired_next;
  logic             w_tick;
  logic             w_running;
  logic             w_warning;

  tick_prescaler #(.DIV(CLK_HZ / TICK_HZ)) u_prescaler (
    .clockIn (clockIn),
    .reset   (reset),
    .tick    (w_tick)
  );

  always_ff @(posedge clockIn or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_sec_count   <= '0;
      r_session_len <= '0;
      r_remaining   <= '0;
      r_sec_tick    <= 1'b0;
      r_expired     <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_sec_count   <= w_sec_count_next;
      r_session_len <= w_session_len_next;
      r_remaining   <= w_remaining_next;
      r_sec_tick    <= w_sec_tick_next;
      r_expired     <= w_expired_next;
    end
  end

  // Priority: abort > start > activity > pause/countdown.
  always_comb begin
    w_state_next       = r_state;
    w_sec_count_next   = r_sec_count;
    w_session_len_next = r_session_len;
    w_remaining_next   = r_remaining;
    w_sec_tick_next    = 1'b0;
    w_expired_next     = 1'b0;

    if (bus.abort) begin
      w_state_next     = IDLE;
      w_remaining_next = '0;
      w_sec_count_next = '0;
    end else if (bus.start) begin
      w_session_len_next = (bus.timeoutLoad == 8'd0) ? DEFAULT_LEN : bus.timeoutLoad;
      w_remaining_next   = (bus.timeoutLoad == 8'd0) ? DEFAULT_LEN : bus.timeoutLoad;
      w_sec_count_next   = '0;
      w_state_next       = bus.pause ? PAUSE : RUN;
    end else if (bus.activity && w_running) begin
      w_remaining_next = r_session_len;
      w_sec_count_next = '0;
    end else begin
      case (r_state)
        RUN: begin
          if (bus.pause) begin
            w_state_next = PAUSE;
          end
          // A second completing in the cycle pause rises is still counted.
          if (w_tick) begin
            if (r_sec_count == SEC_LAST) begin
              w_sec_count_next = '0;
              w_sec_tick_next  = 1'b1;
              if (r_remaining <= 8'd1) begin
                w_remaining_next = '0;
                w_state_next     = EXPIRED;
                w_expired_next   = 1'b1;
              end else begin
                w_remaining_next = r_remaining - 8'd1;
              end
            end else begin
              w_sec_count_next = r_sec_count + 1'b1;
            end
          end
        end
        PAUSE: begin
          if (!bus.pause) begin
            w_state_next = RUN;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign w_running = (r_state == RUN) || (r_state == PAUSE);
  assign w_warning = (WARN_S != 0) && w_running && (r_remaining <= WARN_LEN);

  assign bus.tick      = w_tick;
  assign bus.secTick   = r_sec_tick;
  assign bus.remaining = r_remaining;
  assign bus.running   = w_running;
  assign bus.warning   = w_warning;
  assign bus.expired   = r_expired;
  assign bus.timedOut  = (r_state == EXPIRED);

`ifdef SESSION_WARN_BEEP_EN
  localparam int                BEEP_DIV  = (TICK_HZ / 4 < 1) ? 1 : TICK_HZ / 4;
  localparam int                BEEP_W    = presc_width(BEEP_DIV);
  localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_DIV - 1);

  logic [BEEP_W-1:0] r_beep_count;
  logic              r_beep;

  // Half-period of the 2 Hz buzzer tone is a quarter second of ticks.
  always_ff @(posedge clockIn or posedge reset) begin
    if (reset) begin
      r_beep_count <= '0;
      r_beep       <= 1'b0;
    end else if (!w_warning) begin
      r_beep_count <= '0;
      r_beep       <= 1'b0;
    end else if (w_tick) begin
      if (r_beep_count == BEEP_LAST) begin
        r_beep_count <= '0;
        r_beep       <= ~r_beep;
      end else begin
        r_beep_count <= r_beep_count + 1'b1;
      end
    end
  end

  assign bus.beepOut = r_beep;
`endif

endmodule

// File: tb/tb_session_timeout_ctrl.sv
// Directed bench for session_timeout_ctrl at CLK_HZ=40, TICK_HZ=4, TIMEOUT_S=3, WARN_S=1.
module tb_session_timeout_ctrl;

  logic clockIn = 1'b0;
  logic reset   = 1'b1;
  int   errors  = 0;
  int   checks  = 0;
  int   expired_count = 0;

  session_timeout_ctrl_if bus();

  session_timeout_ctrl #(
    .CLK_HZ    (40),
    .TICK_HZ   (4),
    .TIMEOUT_S (3),
    .WARN_S    (1)
  ) dut (
    .clockIn (clockIn),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clockIn = ~clockIn;

  always @(negedge clockIn) begin
    if (bus.expired === 1'b1) expired_count <= expired_count + 1;
  end

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clockIn);
  endtask

  // Stops on a negedge where tick is high so the next posedge is a tick edge.
  task automatic align_tick(output bit found);
    int n;
    n = 0;
    @(negedge clockIn);
    while (bus.tick !== 1'b1 && n < 25) begin
      @(negedge clockIn);
      n++;
    end
    found = (bus.tick === 1'b1);
  endtask

  task automatic pulse_start(input logic [7:0] load);
    bus.timeoutLoad = load;
    bus.start = 1'b1;
    @(negedge clockIn);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clockIn);
    checks++;
    if ({bus.tick, bus.secTick, bus.running, bus.warning, bus.expired, bus.timedOut} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: flags=%b expected 000000", {bus.tick, bus.secTick, bus.running, bus.warning, bus.expired, bus.timedOut});
    end
    checks++;
    if (bus.remaining !== 8'd0) begin
      errors++;
      $display("FAIL reset_remaining: remaining=%0d expected 0", bus.remaining);
    end
    reset = 1'b0;
    $display("reset released");
  endtask

  task automatic test_idle_tick();
    logic exp_tick;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clockIn);
      exp_tick = (k % 10 == 0);
      checks++;
      if (bus.tick !== exp_tick) begin
        errors++;
        $display("FAIL idle_tick: cycle %0d tick=%b expected %b", k, bus.tick, exp_tick);
      end
    end
    checks++;
    if ({bus.running, bus.timedOut, bus.remaining} !== 10'd0) begin
      errors++;
      $display("FAIL idle_state: running=%b timedOut=%b remaining=%0d expected 0 0 0", bus.running, bus.timedOut, bus.remaining);
    end
    $display("idle tick: 100 cycles checked");
  endtask

  task automatic test_countdown();
    bit found;
    int snap;
    align_tick(found);
    checks++;
    if (!found) begin errors++; $display("FAIL t2_align: tick not seen, expected tick within 25 cycles"); end
    snap = expired_count;
    pulse_start(8'd0);
    checks++;
    if (bus.remaining !== 8'd3 || bus.running !== 1'b1 || bus.warning !== 1'b0) begin
      errors++;
      $display("FAIL t2_start: remaining=%0d running=%b warning=%b expected 3 1 0", bus.remaining, bus.running, bus.warning);
    end
    idle_cycles(39);
    checks++;
    if (bus.remaining !== 8'd3 || bus.secTick !== 1'b0) begin
      errors++;
      $display("FAIL t2_before_first: remaining=%0d secTick=%b expected 3 0", bus.remaining, bus.secTick);
    end
    idle_cycles(1);
    checks++;
    if (bus.remaining !== 8'd2 || bus.secTick !== 1'b1) begin
      errors++;
      $display("FAIL t2_first_dec: remaining=%0d secTick=%b expected 2 1", bus.remaining, bus.secTick);
    end
    idle_cycles(40);
    checks++;
    if (bus.remaining !== 8'd1 || bus.warning !== 1'b1) begin
      errors++;
      $display("FAIL t2_second_dec: remaining=%0d warning=%b expected 1 1", bus.remaining, bus.warning);
    end
    idle_cycles(39);
    checks++;
    if (bus.remaining !== 8'd1 || bus.expired !== 1'b0 || bus.timedOut !== 1'b0) begin
      errors++;
      $display("FAIL t2_pre_expiry: remaining=%0d expired=%b timedOut=%b expected 1 0 0", bus.remaining, bus.expired, bus.timedOut);
    end
    idle_cycles(1);
    checks++;
    if ({bus.remaining, bus.expired, bus.timedOut, bus.running, bus.warning} !== {8'd0, 4'b1100}) begin
      errors++;
      $display("FAIL t2_expiry: remaining=%0d expired=%b timedOut=%b running=%b warning=%b expected 0 1 1 0 0",
               bus.remaining, bus.expired, bus.timedOut, bus.running, bus.warning);
    end
    idle_cycles(20);
    checks++;
    if (bus.timedOut !== 1'b1 || expired_count - snap != 1) begin
      errors++;
      $display("FAIL t2_sticky: timedOut=%b expired pulses=%0d expected 1 1", bus.timedOut, expired_count - snap);
    end
    $display("countdown: 3->0 sequence done");
  endtask

  task automatic test_activity();
    bit found;
    align_tick(found);
    checks++;
    if (!found) begin errors++; $display("FAIL t3_align: tick not seen, expected tick within 25 cycles"); end
    pulse_start(8'd0);
    idle_cycles(29);
    checks++;
    if (bus.tick !== 1'b1) begin
      errors++;
      $display("FAIL t3_phase: tick=%b expected 1", bus.tick);
    end
    bus.activity = 1'b1;
    @(negedge clockIn);
    bus.activity = 1'b0;
    idle_cycles(10);
    checks++;
    if (bus.remaining !== 8'd3) begin
      errors++;
      $display("FAIL t3_no_old_dec: remaining=%0d expected 3", bus.remaining);
    end
    idle_cycles(29);
    checks++;
    if (bus.remaining !== 8'd3) begin
      errors++;
      $display("FAIL t3_before_dec: remaining=%0d expected 3", bus.remaining);
    end
    idle_cycles(1);
    checks++;
    if (bus.remaining !== 8'd2) begin
      errors++;
      $display("FAIL t3_dec: remaining=%0d expected 2", bus.remaining);
    end
    $display("activity: reload and re-timed decrement checked");
  endtask

  task automatic test_pause();
    bit found;
    bit hold_ok;
    align_tick(found);
    checks++;
    if (!found) begin errors++; $display("FAIL t4_align: tick not seen, expected tick within 25 cycles"); end
    pulse_start(8'd0);
    idle_cycles(19);
    bus.pause = 1'b1;
    hold_ok = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clockIn);
      if (bus.remaining !== 8'd3 || bus.secTick !== 1'b0 || bus.running !== 1'b1) hold_ok = 1'b0;
    end
    bus.pause = 1'b0;
    checks++;
    if (hold_ok !== 1'b1) begin
      errors++;
      $display("FAIL t4_hold: hold_ok=%b expected 1 (remaining=%0d)", hold_ok, bus.remaining);
    end
    idle_cycles(20);
    checks++;
    if (bus.remaining !== 8'd3) begin
      errors++;
      $display("FAIL t4_before_resume_dec: remaining=%0d expected 3", bus.remaining);
    end
    idle_cycles(1);
    checks++;
    if (bus.remaining !== 8'd2) begin
      errors++;
      $display("FAIL t4_resume_dec: remaining=%0d expected 2", bus.remaining);
    end
    $display("pause: hold and resume checked");
  endtask

  task automatic test_abort_priority();
    bit found;
    int snap;
    align_tick(found);
    checks++;
    if (!found) begin errors++; $display("FAIL t5_align: tick not seen, expected tick within 25 cycles"); end
    pulse_start(8'd0);
    idle_cycles(40);
    checks++;
    if (bus.remaining !== 8'd2) begin
      errors++;
      $display("FAIL t5_pre: remaining=%0d expected 2", bus.remaining);
    end
    bus.abort = 1'b1;
    bus.activity = 1'b1;
    @(negedge clockIn);
    bus.abort = 1'b0;
    bus.activity = 1'b0;
    snap = expired_count;
    checks++;
    if ({bus.remaining, bus.running, bus.timedOut} !== 10'd0) begin
      errors++;
      $display("FAIL t5_abort: remaining=%0d running=%b timedOut=%b expected 0 0 0", bus.remaining, bus.running, bus.timedOut);
    end
    idle_cycles(100);
    checks++;
    if (expired_count != snap || bus.remaining !== 8'd0) begin
      errors++;
      $display("FAIL t5_quiet: expired pulses=%0d remaining=%0d expected 0 0", expired_count - snap, bus.remaining);
    end
    pulse_start(8'd5);
    checks++;
    if (bus.remaining !== 8'd5 || bus.running !== 1'b1) begin
      errors++;
      $display("FAIL t5_load5: remaining=%0d running=%b expected 5 1", bus.remaining, bus.running);
    end
    $display("abort priority: abort+activity and reload 5 checked");
  endtask

  task automatic test_async_reset();
    bit found;
    idle_cycles(2);
    checks++;
    if (bus.remaining !== 8'd5 || bus.running !== 1'b1) begin
      errors++;
      $display("FAIL t6_pre: remaining=%0d running=%b expected 5 1", bus.remaining, bus.running);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.remaining, bus.tick, bus.secTick, bus.running, bus.warning, bus.expired, bus.timedOut} !== 14'd0) begin
      errors++;
      $display("FAIL t6_async: remaining=%0d flags=%b expected 0 000000", bus.remaining,
               {bus.tick, bus.secTick, bus.running, bus.warning, bus.expired, bus.timedOut});
    end
    @(negedge clockIn);
    reset = 1'b0;
    align_tick(found);
    checks++;
    if (!found) begin errors++; $display("FAIL t6_align: tick not seen, expected tick within 25 cycles"); end
    pulse_start(8'd1);
    checks++;
    if (bus.remaining !== 8'd1 || bus.warning !== 1'b1) begin
      errors++;
      $display("FAIL t6_len1: remaining=%0d warning=%b expected 1 1", bus.remaining, bus.warning);
    end
    idle_cycles(40);
    checks++;
    if (bus.expired !== 1'b1 || bus.timedOut !== 1'b1 || bus.remaining !== 8'd0) begin
      errors++;
      $display("FAIL t6_expire: expired=%b timedOut=%b remaining=%0d expected 1 1 0", bus.expired, bus.timedOut, bus.remaining);
    end
    idle_cycles(5);
    pulse_start(8'd0);
    checks++;
    if (bus.running !== 1'b1 || bus.timedOut !== 1'b0 || bus.remaining !== 8'd3) begin
      errors++;
      $display("FAIL t6_restart: running=%b timedOut=%b remaining=%0d expected 1 0 3", bus.running, bus.timedOut, bus.remaining);
    end
    $display("async reset and restart from EXPIRED checked");
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.activity    = 1'b0;
    bus.pause       = 1'b0;
    bus.abort       = 1'b0;
    bus.timeoutLoad = 8'd0;
    test_reset();
    test_idle_tick();
    test_countdown();
    test_activity();
    test_pause();
    test_abort_priority();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
